// File: rtl/demux_1_4.sv
// 1-to-4 demultiplexer with a one-entry valid/ready skid register per channel and a sticky upstream protocol checker.
// Optional per-channel delivery counters are built only when DEMUX_STATS_EN is defined.

module demux_lane #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic [DATA_W-1:0] data,
  output logic [7:0]        cnt
);

  // A load on the same edge as a drain wins, so the channel stays FULL with the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= din;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

`ifdef DEMUX_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       cnt <= '0;
    else if (drain && cnt != 8'hFF) cnt <= cnt + 8'd1;
  end
`else
  assign cnt = '0;
`endif

endmodule

module demux_1_4 #(
  parameter int DATA_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [1:0]          in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [4*DATA_W-1:0] out_data,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic                err,
  output logic [31:0]         cnt
);

  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic              stall;
    logic [1:0]        sel;
    logic [DATA_W-1:0] data;
  } trk_t;

  logic [NUM_LANES-1:0][DATA_W-1:0] lane_data;
  logic [NUM_LANES-1:0][7:0]        lane_cnt;
  logic [NUM_LANES-1:0]             lane_full;
  logic                             accept;
  trk_t                             trk;

  assign in_ready  = !lane_full[in_sel] || out_ready[in_sel];
  assign accept    = in_valid && in_ready;
  assign out_valid = lane_full;
  assign out_data  = lane_data;
  assign cnt       = lane_cnt;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    demux_lane #(.DATA_W(DATA_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (accept && (in_sel == k[1:0])),
      .drain (lane_full[k] && out_ready[k]),
      .din   (in_data),
      .full  (lane_full[k]),
      .data  (lane_data[k]),
      .cnt   (lane_cnt[k])
    );
  end

  // A stalled word must be presented unchanged on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk <= '0;
      err <= 1'b0;
    end else begin
      trk.stall <= in_valid && !in_ready;
      trk.sel   <= in_sel;
      trk.data  <= in_data;
      if (trk.stall && (!in_valid || in_sel != trk.sel || in_data != trk.data))
        err <= 1'b1;
    end
  end

endmodule

// File: doc/demux_1_4.md
DEMUX_1_4 -- requirements
Module: demux_1_4

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, giving the data width per channel.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_data, input, DATA_W bits: the upstream data word.
REQ-005 The block SHALL have port in_sel, input, 2 bits: the destination channel (00=ch0 .. 11=ch3).
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the word this cycle.
REQ-008 The block SHALL have port out_data, output, 4*DATA_W bits: channel k data on bits [k*DATA_W +: DATA_W].
REQ-009 The block SHALL have port out_valid, output, 4 bits: per-channel valid.
REQ-010 The block SHALL have port out_ready, input, 4 bits: per-channel downstream ready.
REQ-011 The block SHALL have port err, output, 1 bit: sticky upstream protocol-violation flag.
REQ-012 The block SHALL have port cnt, output, 32 bits: channel k delivery count on bits [8k+7:8k].

Function
REQ-013 Each channel SHALL hold a one-entry register with two states, EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-014 in_ready SHALL be combinational: in_ready = !out_valid[in_sel] || out_ready[in_sel].
REQ-015 An accept SHALL be defined as in_valid && in_ready; on an accept, channel in_sel SHALL load in_data and go FULL at the same edge (latency 1 cycle to out_valid).
REQ-016 A drain SHALL be defined as out_valid[k] && out_ready[k]; a drain SHALL take channel k to EMPTY unless the same edge has an accept for k.
REQ-017 A simultaneous drain and accept on one channel SHALL leave the channel FULL holding the new word, giving full throughput of 1 word/cycle.
REQ-018 A channel not addressed by an accept SHALL retain its data; out_data for an EMPTY channel SHALL hold its last value.
REQ-019 A FULL channel with out_ready[k]=0 SHALL stall only words addressed to k; the other channels SHALL continue independently.
REQ-020 A stall SHALL be defined as in_valid=1 with in_ready=0.
REQ-021 If a stall is followed in the next cycle by in_valid=0, or by a change in in_data or in_sel, err SHALL set and remain 1 until reset.
REQ-022 Words SHALL never be dropped or duplicated; order SHALL be preserved per channel.

Reset
REQ-023 While rst=1, out_valid SHALL be 4'b0000, out_data SHALL be all zero, err SHALL be 0, cnt SHALL be 0, and the stall-tracking state SHALL be cleared.
REQ-024 A reset mid-operation SHALL discard all buffered words immediately (asynchronous reset).
REQ-025 While rst=1, in_ready SHALL follow REQ-014 with all channels EMPTY (i.e. 1), but no word SHALL be captured.

Configuration
REQ-026 When macro DEMUX_STATS_EN is defined, cnt[8k+7:8k] SHALL increment by 1 on each drain of channel k and saturate at 255.
REQ-027 When DEMUX_STATS_EN is undefined, cnt SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-028 Reset, then send in_data=4'hA, in_sel=2'b10 with out_ready=4'b1111 -> the next cycle shows out_valid=4'b0100 and out_data[11:8]=4'hA; err=0.
REQ-029 With out_ready[1]=0, send 4'h3 and then 4'h5 to ch1 -> the first is accepted; in_ready=0 for the second; the second holds 4'h5; set out_ready[1]=1 -> 4'h3 drains and 4'h5 loads at the same edge; no loss.
REQ-030 Stall ch0 with out_ready[0]=0 and send 4'h7 to ch3 -> it is accepted; out_valid[3]=1 while ch0 stays FULL.
REQ-031 Stall a word, then change in_sel before acceptance -> err=1 the next cycle and stays 1 until rst.
REQ-032 Fill all four channels, then assert rst mid-cycle -> out_valid=0, out_data=0, and cnt=0 immediately.
REQ-033 With DEMUX_STATS_EN defined, stream 300 words to ch2 -> cnt[23:16]=255 and the other count fields=0; with the macro undefined, cnt=0 throughout.
